// File: rtl/qa_drv_prim_scoreboard_multi.sv
// ---------------------------------------------------------------------------
// qa_drv_prim_scoreboard_multi
//
// Multi-channel reorder scoreboard. Each channel is an ordered ring of
// N_ENTRIES slots. A slot is allocated with enq_en, which stores its meta-data.
// Its payload arrives later and in any order through enqData_en. The output
// side merges the channels. It offers the oldest slot of a channel only once
// that slot's payload has arrived. Round-robin arbitration picks among the
// channels that have a ready head, so one stalled channel never blocks another.
//
// Optional build macro:
//   QA_SCOREBOARD_MULTI_ERR_CHECK_EN - when defined, enables sticky protocol
//   error detection on the payload-write path. When undefined, error is tied
//   to 0 and no checking logic is built.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-high reset
//   enq_en       in   allocate the next slot of enqChan
//   enqChan      in   channel to allocate in
//   enqMeta      in   meta-data stored with the allocated slot
//   notFull      out  per-channel allocate-ready
//   enqIdx       out  slot index that the current enq in enqChan receives
//   enqData_en   in   payload write strobe (always accepted)
//   enqDataChan  in   payload channel
//   enqDataIdx   in   payload slot index
//   enqData      in   payload
//   deq_en       in   consume the offered head
//   notEmpty     out  a head is offered
//   first        out  payload of the offered head
//   firstMeta    out  meta-data of the offered head
//   firstChan    out  channel of the offered head
//   error        out  sticky protocol-error flag
// ---------------------------------------------------------------------------
module qa_drv_prim_scoreboard_multi #(
  parameter int N_CHANNELS     = 4,
  parameter int N_ENTRIES      = 32,
  parameter int N_DATA_BITS    = 64,
  parameter int N_META_BITS    = 1,
  parameter int MIN_FREE_SLOTS = 1,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_en,
  input  logic [CW-1:0]          enqChan,
  input  logic [N_META_BITS-1:0] enqMeta,
  output logic [N_CHANNELS-1:0]  notFull,
  output logic [IW-1:0]          enqIdx,
  input  logic                   enqData_en,
  input  logic [CW-1:0]          enqDataChan,
  input  logic [IW-1:0]          enqDataIdx,
  input  logic [N_DATA_BITS-1:0] enqData,
  input  logic                   deq_en,
  output logic                   notEmpty,
  output logic [N_DATA_BITS-1:0] first,
  output logic [N_META_BITS-1:0] firstMeta,
  output logic [CW-1:0]          firstChan,
  output logic                   error
);

  localparam int OW = IW + 1;
  localparam int AW = CW + IW;

  // Elaboration guards: the pointer arithmetic relies on natural wrap.
  if ((N_ENTRIES < 2) || ((N_ENTRIES & (N_ENTRIES - 1)) != 0)) begin : g_bad_entries
    $fatal(1, "N_ENTRIES must be a power of 2 and at least 2");
  end
  if ((N_CHANNELS < 1) || ((N_CHANNELS & (N_CHANNELS - 1)) != 0)) begin : g_bad_channels
    $fatal(1, "N_CHANNELS must be a power of 2");
  end

  // Flattened per-channel state, driven from the per-channel generate blocks.
  logic [N_CHANNELS-1:0][IW-1:0]        oldest_all;
  logic [N_CHANNELS-1:0][IW-1:0]        newest_all;
  logic [N_CHANNELS-1:0][OW-1:0]        occ_all;
  logic [N_CHANNELS-1:0][N_ENTRIES-1:0] valid_all;
  logic [N_CHANNELS-1:0]                head_rdy;

  logic          enq_ok;
  logic          deq_ok;
  logic [CW-1:0] rr_q;
  logic [CW-1:0] rr_d;
  logic [CW-1:0] sel_chan;
  logic          sel_found;
  logic [CW-1:0] cand;

  // Payload and meta storage. The address is {channel, slot}. This storage is
  // deliberately not reset.
  logic [N_DATA_BITS-1:0] data_mem [2**AW];
  logic [N_META_BITS-1:0] meta_mem [2**AW];

  // An allocation into a full channel is dropped.
  assign enq_ok = enq_en && (occ_all[enqChan] != OW'(N_ENTRIES));
  assign enqIdx = newest_all[enqChan];
  assign deq_ok = deq_en && notEmpty;

  // ---------------------------------------------------------------------------
  // Per-channel ring state
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
      logic [IW-1:0]        oldest_q, oldest_d;
      logic [IW-1:0]        newest_q, newest_d;
      logic [OW-1:0]        occ_q, occ_d;
      logic [N_ENTRIES-1:0] valid_q, valid_d;
      logic                 enq_hit, deq_hit, wr_hit;

      assign enq_hit = enq_ok && (enqChan == CW'(gi));
      assign deq_hit = deq_ok && (sel_chan == CW'(gi));
      assign wr_hit  = enqData_en && (enqDataChan == CW'(gi));

      always_comb begin
        oldest_d = oldest_q;
        newest_d = newest_q;
        occ_d    = occ_q;
        valid_d  = valid_q;
        if (enq_hit) newest_d = newest_q + IW'(1);
        if (deq_hit) begin
          oldest_d          = oldest_q + IW'(1);
          valid_d[oldest_q] = 1'b0;
        end
        // An enq and a deq in the same cycle cancel in the occupancy count.
        occ_d = occ_q + OW'(enq_hit) - OW'(deq_hit);
        // The payload write is applied after the dequeue clear, so a write
        // that collides with the head being dequeued leaves the slot valid.
        if (wr_hit) valid_d[enqDataIdx] = 1'b1;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          oldest_q <= '0;
          newest_q <= '0;
          occ_q    <= '0;
          valid_q  <= '0;
        end else begin
          oldest_q <= oldest_d;
          newest_q <= newest_d;
          occ_q    <= occ_d;
          valid_q  <= valid_d;
        end
      end

      assign oldest_all[gi] = oldest_q;
      assign newest_all[gi] = newest_q;
      assign occ_all[gi]    = occ_q;
      assign valid_all[gi]  = valid_q;
      assign head_rdy[gi]   = valid_all[gi][oldest_q] && (occ_q != '0);
      assign notFull[gi]    = (N_ENTRIES - int'(occ_q)) >= MIN_FREE_SLOTS;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin merge: search starts at the channel after the last dequeue.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_found = 1'b0;
    sel_chan  = rr_q;
    cand      = rr_q;
    for (int i = 0; i < N_CHANNELS; i++) begin
      cand = rr_q + CW'(i);
      if (!sel_found && head_rdy[cand]) begin
        sel_found = 1'b1;
        sel_chan  = cand;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (deq_ok) rr_d = (N_CHANNELS == 1) ? '0 : sel_chan + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  assign notEmpty  = sel_found;
  assign firstChan = sel_chan;
  assign first     = data_mem[{sel_chan, oldest_all[sel_chan]}];
  assign firstMeta = meta_mem[{sel_chan, oldest_all[sel_chan]}];

  always_ff @(posedge clk) begin
    if (enqData_en) data_mem[{enqDataChan, enqDataIdx}] <= enqData;
  end

  always_ff @(posedge clk) begin
    if (enq_ok) meta_mem[{enqChan, newest_all[enqChan]}] <= enqMeta;
  end

  // ---------------------------------------------------------------------------
  // Optional protocol checking on the payload-write path
  // ---------------------------------------------------------------------------
`ifdef QA_SCOREBOARD_MULTI_ERR_CHECK_EN
  logic          error_q;
  logic [IW-1:0] wr_off;
  logic          wr_alloc;
  logic          wr_dup;
  logic          wr_collide;

  // A slot is allocated when its distance from oldest is below occupancy.
  assign wr_off     = enqDataIdx - oldest_all[enqDataChan];
  assign wr_alloc   = {1'b0, wr_off} < occ_all[enqDataChan];
  assign wr_dup     = valid_all[enqDataChan][enqDataIdx];
  assign wr_collide = deq_ok && (enqDataChan == sel_chan) &&
                      (enqDataIdx == oldest_all[sel_chan]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) error_q <= 1'b0;
    else if (enqData_en && (!wr_alloc || wr_dup || wr_collide)) error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

`ifndef SYNTHESIS
  // Simulation-only traps for dropped requests.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enq_en && !enq_ok) $fatal(1, "enq_en on full channel %0d", enqChan);
      if (deq_en && !notEmpty) $fatal(1, "deq_en while notEmpty is low");
    end
  end
`endif

endmodule

// File: tb/tb_qa_drv_prim_scoreboard_multi.sv
module tb_qa_drv_prim_scoreboard_multi;
  localparam int NC = 4;
  localparam int NE = 4;
  localparam int DW = 16;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enq_en = 1'b0;
  logic [1:0]    enqChan = '0;
  logic [MW-1:0] enqMeta = '0;
  logic [NC-1:0] notFull;
  logic [1:0]    enqIdx;
  logic          enqData_en = 1'b0;
  logic [1:0]    enqDataChan = '0;
  logic [1:0]    enqDataIdx = '0;
  logic [DW-1:0] enqData = '0;
  logic          deq_en = 1'b0;
  logic          notEmpty;
  logic [DW-1:0] first;
  logic [MW-1:0] firstMeta;
  logic [1:0]    firstChan;
  logic          error;

  qa_drv_prim_scoreboard_multi #(
    .N_CHANNELS(NC), .N_ENTRIES(NE), .N_DATA_BITS(DW),
    .N_META_BITS(MW), .MIN_FREE_SLOTS(1)
  ) dut (
    .clk(clk), .reset(reset),
    .enq_en(enq_en), .enqChan(enqChan), .enqMeta(enqMeta),
    .notFull(notFull), .enqIdx(enqIdx),
    .enqData_en(enqData_en), .enqDataChan(enqDataChan),
    .enqDataIdx(enqDataIdx), .enqData(enqData),
    .deq_en(deq_en), .notEmpty(notEmpty), .first(first),
    .firstMeta(firstMeta), .firstChan(firstChan), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]    ch;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } exp_t;
  exp_t sb[$];

  // Allocation-stream vectors used for the fill test of channel 3.
  typedef struct {
    logic [MW-1:0] meta;
    logic [NC-1:0] exp_nf;
  } vec_t;
  vec_t tbl[4];

  logic [1:0]    nw[NC];      // bench model of each channel's newest pointer
  logic [DW-1:0] dv[8];
  logic          exp_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_notEmpty", 32'(notEmpty), 32'd0);
    chk("rst_enqIdx", 32'(enqIdx), 32'd0);
    chk("rst_notFull", 32'(notFull), 32'hf);
    chk("rst_firstChan", 32'(firstChan), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    sb.delete();
    for (int c = 0; c < NC; c++) nw[c] = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic enq(input logic [1:0] ch, input logic [MW-1:0] m);
    @(negedge clk);
    enq_en = 1'b1; enqChan = ch; enqMeta = m;
    #1 chk("enqIdx", 32'(enqIdx), 32'(nw[ch]));
    @(posedge clk);
    #1 enq_en = 1'b0;
    $display("enq ch=%0d idx=%0d meta=%0d", ch, nw[ch], m);
    nw[ch] = nw[ch] + 2'd1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] idx, input logic [DW-1:0] d);
    @(negedge clk);
    enqData_en = 1'b1; enqDataChan = ch; enqDataIdx = idx; enqData = d;
    @(posedge clk);
    #1 enqData_en = 1'b0;
    $display("wr  ch=%0d idx=%0d data=%h", ch, idx, d);
  endtask

  task automatic deq();
    exp_t e;
    int   k;
    k = 0;
    @(negedge clk);
    while (!notEmpty && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!notEmpty) begin
      total++; bad++;
      $display("FAIL deq_timeout: notEmpty=0 expected 1");
      return;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL deq_unexpected: chan=%0d expected no output", firstChan);
      return;
    end
    e = sb.pop_front();
    chk("firstChan", 32'(firstChan), 32'(e.ch));
    chk("first", 32'(first), 32'(e.d));
    chk("firstMeta", 32'(firstMeta), 32'(e.m));
    deq_en = 1'b1;
    @(posedge clk);
    #1 deq_en = 1'b0;
    $display("deq ch=%0d data=%h meta=%0d", firstChan, e.d, e.m);
  endtask

  task automatic push(input logic [1:0] ch, input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    e.ch = ch; e.d = d; e.m = m;
    sb.push_back(e);
  endtask

  initial begin
    tbl[0] = '{meta: 2'd1, exp_nf: 4'b1111};
    tbl[1] = '{meta: 2'd2, exp_nf: 4'b1111};
    tbl[2] = '{meta: 2'd3, exp_nf: 4'b1111};
    tbl[3] = '{meta: 2'd0, exp_nf: 4'b0111};
    for (int i = 0; i < 8; i++) dv[i] = DW'($urandom_range(0, 65535));
`ifdef QA_SCOREBOARD_MULTI_ERR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    for (int c = 0; c < NC; c++) nw[c] = '0;

    // Outputs while power-on reset is held.
    #1;
    chk("por_notEmpty", 32'(notEmpty), 32'd0);
    chk("por_notFull", 32'(notFull), 32'hf);
    chk("por_enqIdx", 32'(enqIdx), 32'd0);
    chk("por_error", 32'(error), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Round-robin order 0,1,2,3,0 with every channel ready.
    for (int c = 0; c < NC; c++) enq(2'(c), MW'(c));
    enq(2'd0, 2'd3);
    @(negedge clk);
    chk("rr_wait_empty", 32'(notEmpty), 32'd0);
    for (int c = 0; c < NC; c++) wr(2'(c), 2'd0, dv[c]);
    wr(2'd0, 2'd1, dv[4]);
    for (int c = 0; c < NC; c++) push(2'(c), dv[c], MW'(c));
    push(2'd0, dv[4], 2'd3);
    for (int i = 0; i < 5; i++) deq();

    // Channels do not block each other.
    enq(2'd1, 2'd2);
    enq(2'd2, 2'd1);
    wr(2'd2, nw[2] - 2'd1, dv[5]);
    push(2'd2, dv[5], 2'd1);
    deq();
    chk("ch1_waits", 32'(notEmpty), 32'd0);
    wr(2'd1, nw[1] - 2'd1, dv[6]);
    push(2'd1, dv[6], 2'd2);
    deq();

    // Fill channel 3 to capacity and check notFull and pointer wrap.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      enq(2'd3, tbl[i].meta);
      chk("fill_notFull", 32'(notFull), 32'(tbl[i].exp_nf));
    end
    for (int i = 0; i < 4; i++) begin
      wr(2'd3, 2'(i), dv[i]);
      push(2'd3, dv[i], tbl[i].meta);
    end
    deq();
    chk("nf_after_deq", 32'(notFull), 32'hf);
    enq(2'd3, 2'd2);
    chk("nf_refull", 32'(notFull), 32'b0111);
    enq(2'd0, 2'd1);
    enqChan = 2'd3;
    #1 chk("pending_notEmpty", 32'(notEmpty), 32'd1);
    chk("pending_enqIdx", 32'(enqIdx), 32'd1);

    // Asynchronous reset with five entries pending.
    apply_reset();

    // In-order delivery after out-of-order payload writes on channel 0.
    enq(2'd0, 2'd1);
    enq(2'd0, 2'd0);
    enq(2'd0, 2'd1);
    push(2'd0, dv[0], 2'd1);
    push(2'd0, dv[1], 2'd0);
    push(2'd0, dv[2], 2'd1);
    wr(2'd0, 2'd2, dv[2]);
    wr(2'd0, 2'd1, dv[1]);
    chk("head_not_ready", 32'(notEmpty), 32'd0);
    wr(2'd0, 2'd0, dv[0]);
    for (int i = 0; i < 3; i++) deq();
    chk("no_error", 32'(error), 32'd0);

    // Duplicate payload write.
    enq(2'd1, 2'd0);
    wr(2'd1, 2'd0, dv[7]);
    chk("err_first_wr", 32'(error), 32'd0);
    wr(2'd1, 2'd0, dv[7]);
    chk("err_dup_wr", 32'(error), 32'(exp_err));
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(error), 32'(exp_err));
    apply_reset();
    @(negedge clk);
    chk("post_rst_error", 32'(error), 32'd0);
    chk("post_rst_notEmpty", 32'(notEmpty), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qa_drv_prim_scoreboard_multi.md
QA_DRV_PRIM_SCOREBOARD_MULTI -- requirements
Module: qa_drv_prim_scoreboard_multi

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 4: number of independent ordered streams.
REQ-002 SHALL have parameter N_ENTRIES, default 32: slots per channel; power of 2.
REQ-003 SHALL have parameter N_DATA_BITS, default 64: payload width.
REQ-004 SHALL have parameter N_META_BITS, default 1: meta-data width.
REQ-005 SHALL have parameter MIN_FREE_SLOTS, default 1: per-channel free-slot threshold for notFull.
REQ-006 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have ports enq_en  in  1; enqChan  in  clog2(N_CHANNELS); enqMeta  in  N_META_BITS: allocate slot in enqChan and store meta.
REQ-009 SHALL have ports notFull  out  N_CHANNELS  per-channel allocate-ready; enqIdx  out  clog2(N_ENTRIES)  slot allocated by current enq in enqChan.
REQ-010 SHALL have ports enqData_en  in  1; enqDataChan  in  clog2(N_CHANNELS); enqDataIdx  in  clog2(N_ENTRIES); enqData  in  N_DATA_BITS: payload write, always accepted.
REQ-011 SHALL have ports deq_en  in  1; notEmpty  out  1; first  out  N_DATA_BITS; firstMeta  out  N_META_BITS; firstChan  out  clog2(N_CHANNELS): merged in-order output.
REQ-012 SHALL have port error  out  1  sticky protocol-error flag.

Function
REQ-013 SHALL keep per channel: ring pointers oldest/newest, occupancy counter 0..N_ENTRIES, dataValid vector, data and meta storage.
REQ-014 SHALL drive enqIdx = newest[enqChan]; on enq_en, write meta and increment newest and occupancy of enqChan (pointer wraps N_ENTRIES-1 -> 0).
REQ-015 SHALL assert notFull[c] iff (N_ENTRIES - occ[c]) >= MIN_FREE_SLOTS, from registered state only; MIN_FREE_SLOTS=1 permits all N_ENTRIES used.
REQ-016 SHALL set dataValid[enqDataChan][enqDataIdx] at the edge after enqData_en; notEmpty may rise on the following cycle (1-cycle write-to-ready latency).
REQ-017 SHALL define head-ready[c] = dataValid[c][oldest[c]] with occ[c] != 0.
REQ-018 SHALL select output channel by round-robin over head-ready channels, starting at the channel after the last dequeued one (initially channel 0).
REQ-019 SHALL drive notEmpty, first, firstMeta, firstChan combinationally from registered state only; first/firstMeta hold the head slot of firstChan.
REQ-020 SHALL, on deq_en with notEmpty, clear that head's dataValid, increment oldest and decrement occupancy of firstChan, and move the round-robin pointer past firstChan.
REQ-021 SHALL preserve allocation order within each channel; channels SHALL NOT block one another.
REQ-022 SHALL, on enq and deq on the same channel in one cycle, leave occupancy unchanged and advance both pointers.
REQ-023 SHALL, on enqData_en to the head slot being dequeued in the same cycle, treat it as a protocol error; resulting slot valid = 1.
REQ-024 SHALL ignore enq_en when occ[enqChan] == N_ENTRIES; ignore deq_en when !notEmpty; simulation SHALL $fatal in both cases.
REQ-025 SHALL fail elaboration if N_ENTRIES or N_CHANNELS is not a power of 2.

Reset
REQ-026 SHALL, while reset is high, clear all pointers, occupancies, dataValid and round-robin pointer to 0, independent of clk.
REQ-027 SHALL output notEmpty=0, notFull=all 1s, enqIdx=0, firstChan=0, error=0 during and after reset; data/meta storage is not reset, first/firstMeta are don't-care while notEmpty=0.
REQ-028 SHALL discard all in-flight entries on reset mid-operation; later enqData to pre-reset indices is a protocol error.

Configuration
REQ-029 SHALL, with QA_SCOREBOARD_MULTI_ERR_CHECK_EN defined, set error (sticky until reset) on enqData_en to an unallocated slot or a slot whose dataValid is already 1, or on a REQ-023 collision.
REQ-030 SHALL, without QA_SCOREBOARD_MULTI_ERR_CHECK_EN, tie error to 0 and omit the checking logic; all other behaviour identical.

Verification
REQ-031 Ch0 enq x3 (idx 0,1,2; meta 1,0,1), data written idx 2,1,0 -> outputs in order idx 0,1,2 with matching meta, firstChan=0.
REQ-032 Ch1 enq A, ch2 enq B, only B's data written -> B dequeued with firstChan=2 while ch1 waits; A follows after its data.
REQ-033 Ch0..ch3 all head-ready, deq every cycle -> firstChan sequence 0,1,2,3,0.
REQ-034 N_ENTRIES=4, MIN_FREE_SLOTS=1: 4 enq on ch3 -> notFull[3]=0 after 4th, other bits 1; one deq -> notFull[3]=1; newest wraps to 0.
REQ-035 With ERR_CHECK_EN: write data twice to same slot -> error=1 next cycle and held; reset -> error=0, notEmpty=0, notFull all 1s.
REQ-036 Assert reset mid-stream with 5 entries pending -> notEmpty=0 and enqIdx=0 asynchronously; post-reset traffic behaves as REQ-031.
